// File: rtl/free_list.sv
// Free list of physical register tags: a circular FIFO popped on dispatch and
// pushed on retirement, with a per-ROB-entry head checkpoint for rollback.
module free_list #(
    parameter int NUM_PR  = 64,
    parameter int NUM_ROB = 8
) (
    input  logic                        clock,
    input  logic                        reset,
    input  logic                        en,
    input  logic                        dispatch_en,
    input  logic [4:0]                  dest_idx,
    input  logic [$clog2(NUM_ROB)-1:0]  ROB_idx,
    input  logic                        retire_en,
    input  logic [$clog2(NUM_PR)-1:0]   Told_idx,
    input  logic                        rollback_en,
    input  logic [$clog2(NUM_ROB)-1:0]  ROB_rollback_idx,
    output logic [$clog2(NUM_PR)-1:0]   T_idx,
    output logic                        T_valid,
    output logic [$clog2(NUM_PR-32):0]  free_count,
    output logic                        empty
);

    localparam int FL_SIZE = NUM_PR - 32;
    localparam int PTR_W   = $clog2(FL_SIZE) + 1;
    localparam int IDX_W   = PTR_W - 1;
    localparam int TAG_W   = $clog2(NUM_PR);

    localparam logic [4:0]       ZERO_ARCH = 5'd31;
    localparam logic [TAG_W-1:0] ZERO_TAG  = TAG_W'(31);

    logic [TAG_W-1:0] fl   [FL_SIZE];
    logic [PTR_W-1:0] ckpt [NUM_ROB];
    logic [PTR_W-1:0] head;
    logic [PTR_W-1:0] tail;
    logic [PTR_W-1:0] head_after_pop;
    logic             full;
    logic             pop;
    logic             push;
    logic             ckpt_we;

    // Pointers carry an extra wrap bit so equal low bits distinguish empty from full.
    assign empty      = (head == tail);
    assign full       = (head[IDX_W-1:0] == tail[IDX_W-1:0]) && (head[PTR_W-1] != tail[PTR_W-1]);
    assign free_count = tail - head;
    assign T_valid    = !empty;
    assign T_idx      = (dispatch_en && dest_idx == ZERO_ARCH) ? ZERO_TAG : fl[head[IDX_W-1:0]];

    assign pop     = en && dispatch_en && (dest_idx != ZERO_ARCH) && !empty && !rollback_en;
    assign push    = en && retire_en && (Told_idx != ZERO_TAG) && !full;
    assign ckpt_we = en && dispatch_en && !rollback_en;

    // The checkpoint captures the head after this instruction's own pop,
    // matching the map-table backup that already includes its new mapping.
    assign head_after_pop = pop ? head + PTR_W'(1) : head;

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values of the others, independent of statement order.
    always_ff @(posedge clock) begin
        if (!reset) begin
            // NOTE: the tag array is reset because its initial contents (32..NUM_PR-1)
            // are the architecturally meaningful pool of free tags, not don't-cares.
            for (int i = 0; i < FL_SIZE; i++) begin
                fl[i] <= TAG_W'(32 + i);
            end
            for (int r = 0; r < NUM_ROB; r++) begin
                ckpt[r] <= '0;
            end
            head <= '0;
            tail <= PTR_W'(FL_SIZE);
        end else begin
            if (push) begin
                fl[tail[IDX_W-1:0]] <= Told_idx;
                tail                <= tail + PTR_W'(1);
            end
            if (ckpt_we) begin
                ckpt[ROB_idx] <= head_after_pop;
            end
            // Retirement pushes still land during rollback: those tags belong
            // to instructions older than the mispredict.
            if (en && rollback_en) begin
                head <= ckpt[ROB_rollback_idx];
            end else begin
                head <= head_after_pop;
            end
        end
    end

    push_while_full_a : assert property (
        @(posedge clock) disable iff (!reset)
        !(en && retire_en && (Told_idx != ZERO_TAG) && full)
    );

endmodule

// File: tb/tb_free_list.sv
// Self-checking bench for free_list: directed scenarios plus randomized traffic
// compared against an unbounded-log model of the free tag sequence.
module tb_free_list;

    logic       clock;
    logic       reset;
    logic       en;
    logic       dispatch_en;
    logic [4:0] dest_idx;
    logic [2:0] ROB_idx;
    logic       retire_en;
    logic [5:0] Told_idx;
    logic       rollback_en;
    logic [2:0] ROB_rollback_idx;
    logic [5:0] T_idx;
    logic       T_valid;
    logic [5:0] free_count;
    logic       empty;

    int n_checks;
    int n_fail;

    free_list #(.NUM_PR(64), .NUM_ROB(8)) dut (
        .clock            (clock),
        .reset            (reset),
        .en               (en),
        .dispatch_en      (dispatch_en),
        .dest_idx         (dest_idx),
        .ROB_idx          (ROB_idx),
        .retire_en        (retire_en),
        .Told_idx         (Told_idx),
        .rollback_en      (rollback_en),
        .ROB_rollback_idx (ROB_rollback_idx),
        .T_idx            (T_idx),
        .T_valid          (T_valid),
        .free_count       (free_count),
        .empty            (empty)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Model: every tag ever made free, in FIFO order. h indexes the next tag to
    // hand out; the tail is the log length. Checkpoints are plain log positions.
    int unsigned ent[$];
    int          h;
    int          ck[8];

    function automatic void model_reset();
        ent.delete();
        for (int i = 0; i < 32; i++) ent.push_back(32 + i);
        h = 0;
        for (int i = 0; i < 8; i++) ck[i] = 0;
    endfunction

    function automatic int exp_count();
        return ent.size() - h;
    endfunction

    // Returns -1 when the head entry is stale (empty) and not worth checking.
    function automatic int exp_tag();
        if (dispatch_en && dest_idx == 5'd31) return 31;
        if (exp_count() == 0) return -1;
        return int'(ent[h]);
    endfunction

    task automatic drive(input bit e, input bit d, input int dest, input int rob,
                         input bit r, input int told, input bit rb, input int rbi);
        en               = e;
        dispatch_en      = d;
        dest_idx         = 5'(dest);
        ROB_idx          = 3'(rob);
        retire_en        = r;
        Told_idx         = 6'(told);
        rollback_en      = rb;
        ROB_rollback_idx = 3'(rbi);
        #1;
    endtask

    task automatic idle();
        drive(1, 0, 0, 0, 0, 0, 0, 0);
    endtask

    // Advance one clock and apply the same cycle to the model.
    task automatic tick();
        int  t;
        bit  m_pop;
        bit  m_push;
        @(posedge clock);
        if (!reset) begin
            model_reset();
        end else if (en) begin
            t      = ent.size();
            m_pop  = dispatch_en && dest_idx != 5'd31 && h != t && !rollback_en;
            m_push = retire_en && Told_idx != 6'd31 && (t - h) != 32;
            if (dispatch_en && !rollback_en) ck[ROB_idx] = h + (m_pop ? 1 : 0);
            if (rollback_en) h = ck[ROB_rollback_idx];
            else if (m_pop) h = h + 1;
            if (m_push) ent.push_back(int'(Told_idx));
        end
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b0;
        idle();
        tick();
        reset = 1'b1;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        drive(1, 1, 3, 2, 1, 40, 1, 2);
        tick();
        reset = 1'b1;
        idle();
        n_checks++;
        if (T_idx !== 6'd32) begin
            n_fail++; $display("FAIL reset_T_idx got %0d want 32", T_idx);
        end
        n_checks++;
        if (free_count !== 6'd32) begin
            n_fail++; $display("FAIL reset_free_count got %0d want 32", free_count);
        end
        n_checks++;
        if (T_valid !== 1'b1 || empty !== 1'b0) begin
            n_fail++; $display("FAIL reset_flags got T_valid=%b empty=%b want 1/0", T_valid, empty);
        end
    endtask

    task automatic test_pop_all();
        for (int i = 0; i < 32; i++) begin
            drive(1, 1, 1 + i % 5, i % 8, 0, 0, 0, 0);
            n_checks++;
            if (T_idx !== 6'(32 + i)) begin
                n_fail++; $display("FAIL pop_order[%0d] got %0d want %0d", i, T_idx, 32 + i);
            end
            tick();
        end
        idle();
        n_checks++;
        if (free_count !== 6'd0 || empty !== 1'b1 || T_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL drained got count=%0d empty=%b valid=%b want 0/1/0", free_count, empty, T_valid);
        end
        drive(1, 1, 2, 1, 0, 0, 0, 0);
        tick();
        idle();
        n_checks++;
        if (free_count !== 6'd0 || empty !== 1'b1) begin
            n_fail++; $display("FAIL pop_when_empty got count=%0d empty=%b want 0/1", free_count, empty);
        end
    endtask

    task automatic test_retire_from_empty();
        drive(1, 1, 4, 0, 1, 7, 0, 0);
        tick();
        idle();
        n_checks++;
        if (T_idx !== 6'd7 || free_count !== 6'd1) begin
            n_fail++; $display("FAIL push_from_empty got tag=%0d count=%0d want 7/1", T_idx, free_count);
        end
        drive(1, 1, 2, 1, 1, 9, 0, 0);
        n_checks++;
        if (T_idx !== 6'd7) begin
            n_fail++; $display("FAIL no_bypass got %0d want 7", T_idx);
        end
        tick();
        idle();
        n_checks++;
        if (T_idx !== 6'd9 || free_count !== 6'd1) begin
            n_fail++; $display("FAIL push_pop_same_cycle got tag=%0d count=%0d want 9/1", T_idx, free_count);
        end
    endtask

    task automatic test_rollback();
        do_reset();
        drive(1, 1, 1, 2, 0, 0, 0, 0); tick();
        drive(1, 1, 2, 3, 0, 0, 0, 0); tick();
        drive(1, 1, 3, 4, 0, 0, 0, 0); tick();
        // Dispatch at ROB 5 during rollback must neither pop nor write a checkpoint.
        drive(1, 1, 6, 5, 0, 0, 1, 2); tick(); idle();
        n_checks++;
        if (T_idx !== 6'd33 || free_count !== 6'd31) begin
            n_fail++; $display("FAIL rollback_2 got tag=%0d count=%0d want 33/31", T_idx, free_count);
        end
        drive(1, 0, 0, 0, 0, 0, 1, 5); tick(); idle();
        n_checks++;
        if (T_idx !== 6'd32 || free_count !== 6'd32) begin
            n_fail++; $display("FAIL rollback_ckpt_untouched got tag=%0d count=%0d want 32/32", T_idx, free_count);
        end
        drive(1, 0, 0, 0, 0, 0, 1, 4); tick(); idle();
        n_checks++;
        if (T_idx !== 6'd35 || free_count !== 6'd29) begin
            n_fail++; $display("FAIL rollback_4 got tag=%0d count=%0d want 35/29", T_idx, free_count);
        end
        drive(1, 0, 0, 0, 1, 40, 1, 3); tick(); idle();
        n_checks++;
        if (T_idx !== 6'd34 || free_count !== 6'd31) begin
            n_fail++; $display("FAIL rollback_with_push got tag=%0d count=%0d want 34/31", T_idx, free_count);
        end
    endtask

    task automatic test_zero_reg();
        drive(1, 1, 31, 6, 0, 0, 0, 0);
        n_checks++;
        if (T_idx !== 6'd31) begin
            n_fail++; $display("FAIL zero_dest_tag got %0d want 31", T_idx);
        end
        tick();
        idle();
        n_checks++;
        if (T_idx !== 6'd34 || free_count !== 6'd31) begin
            n_fail++; $display("FAIL zero_dest_no_pop got tag=%0d count=%0d want 34/31", T_idx, free_count);
        end
        drive(1, 0, 0, 0, 1, 31, 0, 0);
        tick();
        idle();
        n_checks++;
        if (free_count !== 6'd31) begin
            n_fail++; $display("FAIL zero_told_no_push got count=%0d want 31", free_count);
        end
    endtask

    task automatic test_wrap();
        int told;
        do_reset();
        for (int i = 0; i < 16; i++) begin
            drive(1, 1, 1, 0, 0, 0, 0, 0);
            tick();
        end
        for (int i = 0; i < 40; i++) begin
            told = int'($urandom % 64);
            if (told == 31) told = 0;
            drive(1, 1, int'($urandom % 31), i % 8, 1, told, 0, 0);
            n_checks++;
            if (T_idx !== 6'(exp_tag())) begin
                n_fail++; $display("FAIL wrap_order[%0d] got %0d want %0d", i, T_idx, exp_tag());
            end
            tick();
            n_checks++;
            if (free_count !== 6'd16) begin
                n_fail++; $display("FAIL wrap_count[%0d] got %0d want 16", i, free_count);
            end
        end
        idle();
        n_checks++;
        if (T_idx !== 6'(exp_tag())) begin
            n_fail++; $display("FAIL wrap_final got %0d want %0d", T_idx, exp_tag());
        end
    endtask

    task automatic test_en_low();
        int c0;
        int t0;
        idle();
        c0 = exp_count();
        t0 = int'(ent[h]);
        for (int i = 0; i < 3; i++) begin
            drive(0, 1, 5, 1, 1, 3, 1, 1);
            tick();
            n_checks++;
            if (free_count !== 6'(c0) || T_idx !== 6'(t0)) begin
                n_fail++;
                $display("FAIL en_low[%0d] got tag=%0d count=%0d want %0d/%0d", i, T_idx, free_count, t0, c0);
            end
        end
        idle();
    endtask

    task automatic test_random();
        bit e, d, r, rb;
        int dest, rob, told, rbi, tail_after;
        do_reset();
        for (int i = 0; i < 400; i++) begin
            reset = ($urandom % 100) != 0;
            e    = ($urandom % 8) != 0;
            d    = ($urandom % 2) != 0;
            dest = int'($urandom % 32);
            rob  = int'($urandom % 8);
            told = int'($urandom % 64);
            r    = (($urandom % 5) < 2) && (exp_count() != 32);
            rb   = ($urandom % 20) == 0;
            rbi  = int'($urandom % 8);
            // Only roll back to checkpoints whose restored window fits in the FIFO.
            tail_after = ent.size() + ((r && told != 31) ? 1 : 0);
            if (tail_after - ck[rbi] > 32) rb = 1'b0;
            drive(e, d, dest, rob, r, told, rb, rbi);
            if (exp_tag() >= 0) begin
                n_checks++;
                if (T_idx !== 6'(exp_tag())) begin
                    n_fail++; $display("FAIL rand_tag[%0d] got %0d want %0d", i, T_idx, exp_tag());
                end
            end
            tick();
            n_checks++;
            if (free_count !== 6'(exp_count()) || empty !== (exp_count() == 0) || T_valid !== (exp_count() != 0)) begin
                n_fail++;
                $display("FAIL rand_state[%0d] got count=%0d empty=%b valid=%b want count=%0d",
                         i, free_count, empty, T_valid, exp_count());
            end
        end
        reset = 1'b1;
        idle();
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        reset    = 1'b0;
        idle();
        test_reset();
        test_pop_all();
        test_retire_from_empty();
        test_rollback();
        test_zero_reg();
        test_wrap();
        test_en_low();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/free_list.md
Name: free_list

Overview:
- Circular FIFO of free physical register (PR) tags. It sits directly upstream of the map table and supplies the new destination tag on every dispatch.
- Retirement returns the retiring instruction's T_old to the tail of the FIFO.
- On every dispatch the head pointer is checkpointed per ROB entry. A rollback restores the head in one cycle, in lockstep with the map table's per-ROB backup.

Parameters:
- NUM_PR, 64, number of physical registers. NUM_PR-32 must be a power of 2.
- NUM_ROB, 8, ROB entries; sets the number of head checkpoints.
- FL_SIZE, NUM_PR-32, FIFO depth (derived, not overridable).

Ports:
- clock  in  1  system clock.
- reset  in  1  synchronous, active-low reset; sampled on posedge clock.
- en  in  1  global advance; when 0, no state changes.
- dispatch_en  in  1  pop request for the instruction being dispatched.
- dest_idx  in  5  architectural destination of the dispatching instruction.
- ROB_idx  in  $clog2(NUM_ROB)  ROB slot allocated to the dispatching instruction.
- retire_en  in  1  push request from ROB retirement.
- Told_idx  in  $clog2(NUM_PR)  tag freed by retirement.
- rollback_en  in  1  branch mispredict recovery.
- ROB_rollback_idx  in  $clog2(NUM_ROB)  ROB slot of the mispredicted instruction.
- T_idx  out  $clog2(NUM_PR)  tag at head, offered to the map table.
- T_valid  out  1  FIFO non-empty.
- free_count  out  $clog2(FL_SIZE)+1  number of free tags.
- empty  out  1  free_count==0.

Behaviour:
- Storage:
  - fl[FL_SIZE] of PR tags.
  - head and tail pointers, each $clog2(FL_SIZE)+1 bits; the MSB is the wrap bit.
  - free_count = tail-head (modular, full pointer width).
  - empty when pointers are equal. Full when the low bits are equal and the wrap bits differ.
- Reset (reset==0 at posedge, regardless of other inputs):
  - fl[i]=32+i; head=0; tail=FL_SIZE with the wrap bit set (full).
  - All checkpoints = 0.
  - Outputs the next cycle: T_idx=32, T_valid=1, free_count=FL_SIZE, empty=0.
  - Reset mid-operation discards all in-flight state.
- Outputs are combinational from registered state:
  - T_idx = fl[head low bits].
  - When empty, T_idx holds the stale entry and T_valid=0.
- Zero register:
  - dispatch with dest_idx==31 does not pop; T_idx is forced to 31 that cycle.
  - retire with Told_idx==31 does not push.
- Pop:
  - Effective when en && dispatch_en && dest_idx!=31 && !empty && !rollback_en.
  - head increments by 1; wrap-around is natural via the pointer width.
  - dispatch_en while empty is ignored: no pop, no pointer change. Upstream gating on T_valid is required.
- Checkpoint:
  - Written when en && dispatch_en && !rollback_en, including dest 31 and the empty case.
  - ckpt[ROB_idx] = next head, i.e. the head after this instruction's pop.
  - This matches the map-table backup, which includes the instruction's own mapping.
- Push:
  - Effective when en && retire_en && Told_idx!=31.
  - fl[tail low bits]=Told_idx; tail increments.
  - Push while full is ignored; simulation assertion fires.
- Rollback (en && rollback_en):
  - head = ckpt[ROB_rollback_idx] next cycle; any dispatch that cycle is ignored.
  - A retire push in the same cycle still applies: retiring instructions are older than the mispredict.
- Simultaneous push and pop:
  - Both apply and free_count is unchanged.
  - If empty at cycle start, only the push applies.
  - A pushed tag is visible on T_idx the next cycle at the earliest; no same-cycle bypass.
- en==0: all registers hold; outputs remain valid.

Test Plan:
- Reset: hold reset=0 one cycle, release -> T_idx=32, free_count=32, T_valid=1, empty=0.
- Pop 32 times with dest_idx=1..5 -> tags 32..63 in order. Then free_count=0, empty=1, T_valid=0. A further dispatch_en leaves head unchanged.
- From empty, retire Told_idx=7 -> next cycle T_idx=7, free_count=1. Same-cycle dispatch+retire with free_count=1 -> free_count stays 1 and the new tag is offered after the head tag.
- Dispatch at ROB_idx=2 (pop 32), ROB_idx=3 (pop 33), ROB_idx=4 (pop 34). Rollback with ROB_rollback_idx=2 -> T_idx=33, free_count=31. The dispatch asserted in the rollback cycle is ignored.
- Dispatch dest_idx=31 -> T_idx=31, head unchanged. Retire Told_idx=31 -> tail unchanged.
- Pointer wrap: 40 interleaved pop/push pairs around the index-31/0 boundary -> FIFO order preserved, free_count constant. en=0 for 3 cycles with requests asserted -> no state change.
